// File: rtl/btb_sa_pkg.sv
// Branch target buffer types, counter encoding and counter update helper.
package btb_sa_pkg;
  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } btb_cnt_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } btb_state_t;

  localparam btb_cnt_t BTB_CNT_INIT = CNT_WT;

  function automatic btb_cnt_t cnt_update(input btb_cnt_t cnt, input logic taken);
    btb_cnt_t res;
    case (cnt)
      CNT_SNT: res = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: res = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  res = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  res = taken ? CNT_ST  : CNT_WT;
      default: res = BTB_CNT_INIT;
    endcase
    return res;
  endfunction
endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I base types used across the core.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

// File: rtl/btb_plru.sv
// Tree-PLRU touch and victim selection for one set; node bits point at the side to evict next.
module btb_plru #(
  parameter int WAYS = 2,
  parameter int WW   = (WAYS > 1) ? $clog2(WAYS) : 1,
  parameter int PW   = (WAYS > 1) ? WAYS - 1 : 1
) (
  input  logic [PW-1:0] plru_in,
  input  logic          touch,
  input  logic [WW-1:0] touch_way,
  output logic [PW-1:0] plru_out,
  output logic [WW-1:0] victim
);
  generate
    if (WAYS == 4) begin : g_w4
      assign victim = plru_in[0] ? {1'b1, plru_in[2]} : {1'b0, plru_in[1]};
      // Point root and the touched subtree node away from the touched way.
      always_comb begin
        plru_out = plru_in;
        if (touch) begin
          plru_out[0] = ~touch_way[1];
          if (touch_way[1]) begin
            plru_out[2] = ~touch_way[0];
          end else begin
            plru_out[1] = ~touch_way[0];
          end
        end else begin
          plru_out = plru_in;
        end
      end
    end else if (WAYS == 2) begin : g_w2
      assign victim   = plru_in[0];
      assign plru_out = touch ? ~touch_way : plru_in;
    end else begin : g_w1
      logic unused_s;
      assign unused_s = ^{touch, touch_way};
      assign victim   = '0;
      assign plru_out = plru_in;
    end
  endgenerate
endmodule

// File: rtl/btb_sa.sv
// Set-associative BTB with 1-cycle lookup, tree-PLRU replacement and a power-up clear sweep.
// Optional 2-bit direction counters are enabled by defining BTB_DIR_CNT_EN.
module btb_sa
  import btb_sa_pkg::*, rv32i_types::*;
#(
  parameter int IDX_WIDTH = 6,
  parameter int WAYS      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [31:0] r_pc,
  input  logic        load,
  input  logic [31:0] w_pc,
  input  rv32i_word   target_in,
  input  logic        taken_in,
  output rv32i_word   target_out,
  output logic        btb_hit,
  output logic        pred_taken,
  output logic        busy
);
  localparam int SETS  = 1 << IDX_WIDTH;
  localparam int TAG_W = 30 - IDX_WIDTH;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;

  btb_state_t           state_r, state_next_s;
  logic [IDX_WIDTH-1:0] clr_idx_r;
  logic [WAYS-1:0]      valid_r [SETS];
  logic [TAG_W-1:0]     tag_r   [SETS][WAYS];
  rv32i_word            tgt_r   [SETS][WAYS];
`ifdef BTB_DIR_CNT_EN
  btb_cnt_t             cnt_r   [SETS][WAYS];
`endif

  logic [IDX_WIDTH-1:0] r_idx_s, w_idx_s;
  logic [TAG_W-1:0]     r_tag_s, w_tag_s;
  logic [WAYS-1:0]      r_vec_s, w_vec_s;
  logic [WW-1:0]        r_way_s, w_hit_way_s, inv_way_s, alloc_way_s, w_way_s, victim_s;
  logic                 r_hit_s, w_hit_s, run_s, w_en_s, r_touch_s, pred_s;
  logic                 unused_pc_s;

  assign r_idx_s     = r_pc[IDX_WIDTH+1:2];
  assign r_tag_s     = r_pc[31:IDX_WIDTH+2];
  assign w_idx_s     = w_pc[IDX_WIDTH+1:2];
  assign w_tag_s     = w_pc[31:IDX_WIDTH+2];
  assign unused_pc_s = ^{r_pc[1:0], w_pc[1:0]};

  // Per-way tag match for the lookup and update ports.
  always_comb begin
    r_vec_s = '0;
    w_vec_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      r_vec_s[w] = valid_r[r_idx_s][w] && (tag_r[r_idx_s][w] == r_tag_s);
      w_vec_s[w] = valid_r[w_idx_s][w] && (tag_r[w_idx_s][w] == w_tag_s);
    end
  end

  // Encode matching ways and the lowest-numbered invalid way.
  always_comb begin
    r_way_s     = '0;
    w_hit_way_s = '0;
    inv_way_s   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      r_way_s     = r_vec_s[w] ? WW'(w) : r_way_s;
      w_hit_way_s = w_vec_s[w] ? WW'(w) : w_hit_way_s;
      inv_way_s   = valid_r[w_idx_s][w] ? inv_way_s : WW'(w);
    end
  end

  // A hit needs exactly one matching way.
  assign r_hit_s     = (r_vec_s != '0) && ((r_vec_s & (r_vec_s - WAYS'(1'b1))) == '0);
  assign w_hit_s     = (w_vec_s != '0) && ((w_vec_s & (w_vec_s - WAYS'(1'b1))) == '0);
  assign alloc_way_s = (&valid_r[w_idx_s]) ? victim_s : inv_way_s;
  assign w_way_s     = w_hit_s ? w_hit_way_s : alloc_way_s;
  assign run_s       = (state_r == RUN) && !rst;
  assign w_en_s      = load && run_s && (w_hit_s || taken_in);
  assign r_touch_s   = read && run_s && r_hit_s;
  assign busy        = (state_r == CLEAR);

`ifdef BTB_DIR_CNT_EN
  assign pred_s = cnt_r[r_idx_s][r_way_s][1];
`else
  assign pred_s = 1'b1;
`endif

  generate
    if (WAYS > 1) begin : g_plru
      logic [PW-1:0] plru_r [SETS];
      logic [PW-1:0] plru_rd_next_s, plru_wr_in_s, plru_wr_next_s;
      logic [WW-1:0] unused_rd_victim_s;

      btb_plru #(.WAYS(WAYS)) u_plru_rd (
        .plru_in   (plru_r[r_idx_s]),
        .touch     (r_touch_s),
        .touch_way (r_way_s),
        .plru_out  (plru_rd_next_s),
        .victim    (unused_rd_victim_s)
      );

      // The write sees the read's touch first when both hit the same set.
      assign plru_wr_in_s = (r_touch_s && (r_idx_s == w_idx_s)) ? plru_rd_next_s : plru_r[w_idx_s];

      btb_plru #(.WAYS(WAYS)) u_plru_wr (
        .plru_in   (plru_wr_in_s),
        .touch     (w_en_s),
        .touch_way (w_way_s),
        .plru_out  (plru_wr_next_s),
        .victim    (victim_s)
      );

      // PLRU storage: swept to zero while clearing, else read and write touches.
      always_ff @(posedge clk) begin
        if (!rst && state_r == CLEAR) begin
          plru_r[clr_idx_r] <= '0;
        end else begin
          if (r_touch_s) plru_r[r_idx_s] <= plru_rd_next_s;
          if (w_en_s)    plru_r[w_idx_s] <= plru_wr_next_s;
        end
      end
    end else begin : g_no_plru
      assign victim_s = '0;
    end
  endgenerate

  // Clear FSM state and sweep index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_idx_r <= '0;
    end else begin
      state_r   <= state_next_s;
      clr_idx_r <= (state_r == CLEAR) ? clr_idx_r + IDX_WIDTH'(1) : clr_idx_r;
    end
  end

  // Clear FSM next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CLEAR:   state_next_s = (clr_idx_r == '1) ? RUN : CLEAR;
      RUN:     state_next_s = RUN;
      default: state_next_s = CLEAR;
    endcase
  end

  // Valid bits: swept while clearing, set on allocation.
  always_ff @(posedge clk) begin
    if (!rst && state_r == CLEAR) begin
      valid_r[clr_idx_r] <= '0;
    end else if (w_en_s) begin
      valid_r[w_idx_s][w_way_s] <= 1'b1;
    end
  end

  // Entry payload, never reset; valid masks stale contents.
  always_ff @(posedge clk) begin
    if (w_en_s) begin
      tag_r[w_idx_s][w_way_s] <= w_tag_s;
      tgt_r[w_idx_s][w_way_s] <= target_in;
`ifdef BTB_DIR_CNT_EN
      cnt_r[w_idx_s][w_way_s] <= w_hit_s ? cnt_update(cnt_r[w_idx_s][w_way_s], taken_in) : BTB_CNT_INIT;
`endif
    end
  end

  // Registered lookup result, held while read is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_hit    <= 1'b0;
      pred_taken <= 1'b0;
      target_out <= '0;
    end else if (read) begin
      btb_hit    <= run_s && r_hit_s;
      pred_taken <= run_s && r_hit_s && pred_s;
      target_out <= (run_s && r_hit_s) ? tgt_r[r_idx_s][r_way_s] : '0;
    end
  end
endmodule

// File: doc/btb_sa.md
BTB_SA -- requirements
Module: btb_sa

Interface
REQ-001 Parameter IDX_WIDTH, default 6, log2 of the number of sets.
REQ-002 Parameter WAYS, default 2, associativity (legal values: 1, 2, 4).
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port read, input, 1: lookup request.
REQ-006 Port r_pc, input, 32: lookup PC.
REQ-007 Port load, input, 1: branch-resolution update request.
REQ-008 Port w_pc, input, 32: PC of the resolved branch.
REQ-009 Port target_in, input, 32 (rv32i_word): resolved branch target.
REQ-010 Port taken_in, input, 1: resolved branch direction.
REQ-011 Port target_out, output, 32 (rv32i_word): predicted target.
REQ-012 Port btb_hit, output, 1: lookup matched a valid entry.
REQ-013 Port pred_taken, output, 1: predicted direction.
REQ-014 Port busy, output, 1: clear sweep in progress.

Function
REQ-015 Index = pc[IDX_WIDTH+1:2]; tag = pc[31:IDX_WIDTH+2]; pc[1:0] are ignored.
REQ-016 Lookup latency is 1 cycle: with read=1 at edge N, btb_hit, target_out and pred_taken are valid after edge N; they hold their values while read=0.
REQ-017 A hit requires valid=1 and tag equality in exactly one way; target_out = 0 and pred_taken = 0 on a miss.
REQ-018 Write hit (load=1, tag match): target overwritten; counter saturating +1 on taken_in=1, -1 on taken_in=0.
REQ-019 Write miss with taken_in=1: allocate the lowest-numbered invalid way, else the PLRU victim; set valid, tag and target; counter = 2'b10 (weakly taken).
REQ-020 Write miss with taken_in=0: no state change.
REQ-021 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; pred_taken = hit && cnt[1].
REQ-022 Replacement is tree-PLRU with WAYS-1 bits per set; it touches on a read hit and on a write hit or allocate; WAYS=1 has no PLRU state.
REQ-023 Simultaneous read and load to the same set: the read returns pre-write contents; the write's PLRU touch is applied after the read's touch.
REQ-024 While busy=1: load is ignored, and read yields btb_hit=0 and pred_taken=0 in the following cycle.

Reset
REQ-025 rst=1 forces the FSM to CLEAR with sweep index 0, and sets btb_hit=0, pred_taken=0, target_out=0, busy=1.
REQ-026 In CLEAR, one set per cycle gets all valid bits and PLRU bits zeroed; after index 2^IDX_WIDTH-1 the FSM moves to RUN and busy=0.
REQ-027 FSM states are CLEAR and RUN only; RUN leaves only on rst.
REQ-028 rst asserted mid-sweep restarts the sweep from index 0; busy remains high for a full 2^IDX_WIDTH cycles after rst deasserts.
REQ-029 Tag, target and counter arrays are not reset; valid=0 masks their contents.

Configuration
REQ-030 Macro BTB_DIR_CNT_EN defined: 2-bit counters are implemented per REQ-018 to REQ-021.
REQ-031 Macro BTB_DIR_CNT_EN undefined: no counter storage; pred_taken = btb_hit; write hits update only the target; allocation still requires taken_in=1.

Structure
REQ-032 The shared package holds btb_cnt_t (the 2-bit counter enum), btb_state_t (CLEAR, RUN) and the BTB_CNT_INIT constant; rv32i_word is taken from rv32i_types.
REQ-033 The PLRU update and victim-select logic is one sub-module, btb_plru, parametrised by WAYS.

Verification
REQ-034 Scenario: pulse rst for 1 cycle -> busy=1 for 64 cycles; then read r_pc=0x100 -> btb_hit=0.
REQ-035 Scenario: load w_pc=0x100, target_in=0x200, taken_in=1; then read 0x100 -> btb_hit=1, target_out=0x200, pred_taken=1.
REQ-036 Scenario: then two loads to 0x100 with taken_in=0 -> read gives btb_hit=1, pred_taken=0 (cnt=00); one taken load -> cnt=01, pred_taken=0.
REQ-037 Scenario (WAYS=2): allocate 0x100 and 0x1100 (same set), read 0x100, then allocate 0x2100 -> 0x1100 misses, 0x100 and 0x2100 hit.
REQ-038 Scenario: rst at sweep index 20 -> busy stays high for 64 more cycles, and load during busy does not allocate.
REQ-039 Scenario: read and load of 0x300 (taken) in the same cycle -> that read misses; a read of 0x300 in the next cycle hits.
